lc_sram_ctrl: RTL and testbench

- Downstream consumer of the language-card bank/enable logic.
- Turns CPU accesses, together with the card's translated address and its read/write enables, into cycles on the single-port external 256Kx8 SRAM.
- Interleaves video fetches and decides whether the $D000-$FFFF window is served from ROM or card RAM.
- Sits between the CPU/video front end and the SRAM pins.

---
 rtl/apple2_mem_pkg.sv | 37 +++
 rtl/lc_region_decode.sv | 49 ++++
 rtl/lc_sram_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lc_sram_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/apple2_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apple2_mem_pkg
// Description : Shared types and constants for the language-card SRAM
//               controller: FSM state encoding, CPU service classes, region
//               page numbers, open-bus value and the external SRAM width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package apple2_mem_pkg;

  localparam int unsigned SRAM_AW = 18;

  localparam logic [3:0] IO_PAGE  = 4'hC;
  localparam logic [3:0] HI_PAGE  = 4'hD;
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SETUP = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_LATCH = 3'd3,
    ST_WR_SETUP = 3'd4,
    ST_WR_PULSE = 3'd5,
    ST_WR_HOLD  = 3'd6
  } state_t;

  // How a latched CPU access is completed.
  typedef enum logic [1:0] {
    SVC_IO   = 2'd0,  // I/O page: open bus, no SRAM cycle
    SVC_ROM  = 2'd1,  // high window read with card RAM disabled
    SVC_WP   = 2'd2,  // high window write with card RAM write-protected
    SVC_SRAM = 2'd3   // real SRAM cycle
  } svc_t;

endpackage
`default_nettype wire

// File: rtl/lc_region_decode.sv
`default_nettype none
// ============================================================================
// Module      : lc_region_decode
// Description : Combinational region decode for a latched CPU access. Selects
//               the service class and the 18-bit SRAM address.
// Ports       : i_addr      - latched CPU address
//               i_we        - latched CPU write flag
//               i_card_rd   - latched language-card read enable
//               i_card_we   - latched language-card write enable
//               i_card_addr - latched translated card address
//               o_svc       - service class (IO / ROM / WP / SRAM)
//               o_sram_addr - SRAM address for an SRAM-class access
// Revision    : 1.0 - initial release
// ============================================================================
module lc_region_decode
  import apple2_mem_pkg::*;
(
  input  logic [15:0]        i_addr,
  input  logic               i_we,
  input  logic               i_card_rd,
  input  logic               i_card_we,
  input  logic [SRAM_AW-1:0] i_card_addr,
  output svc_t               o_svc,
  output logic [SRAM_AW-1:0] o_sram_addr
);

  logic w_hi;
  logic w_io;

  assign w_hi = (i_addr[15:12] >= HI_PAGE);
  assign w_io = (i_addr[15:12] == IO_PAGE);

  always_comb begin
    o_svc = SVC_SRAM;
    if (w_io) begin
      o_svc = SVC_IO;
    end else if (w_hi && !i_we && !i_card_rd) begin
      o_svc = SVC_ROM;
    end else if (w_hi && i_we && !i_card_we) begin
      o_svc = SVC_WP;
    end
  end

  // The $D000-$FFFF window is remapped by the card; everything else is
  // identity-mapped into the bottom 64K of the SRAM.
  assign o_sram_addr = w_hi ? i_card_addr : {2'b00, i_addr};

endmodule
`default_nettype wire

// File: rtl/lc_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc_sram_ctrl
// Description : Language-card SRAM controller. Captures CPU and video
//               requests into pending slots and runs them on a single-port
//               256Kx8 SRAM, serving video first. I/O, ROM and
//               write-protected CPU accesses complete without an SRAM cycle.
// Ports       : mclk28, reset_in             - clock / sync active-high reset
//               cpu_strobe, cpu_addr, cpu_we, cpu_din       - CPU request
//               card_addr, card_ram_rd, card_ram_we         - card mapping
//               rom_data                     - ROM byte for cpu_addr
//               vid_req, vid_addr            - video fetch request
//               cpu_dout, cpu_ack            - CPU completion
//               vid_dout, vid_ack            - video completion
//               sram_addr, sram_dq_o, sram_dq_oe, sram_dq_i,
//               sram_oe_n, sram_we_n         - SRAM pins
// Revision    : 1.0 - initial release
// ============================================================================
module lc_sram_ctrl
  import apple2_mem_pkg::*;
#(
  parameter int unsigned        SRAM_WAIT = 1,
  parameter logic [SRAM_AW-1:0] VID_BASE  = 18'h00000
) (
  input  logic               mclk28,
  input  logic               reset_in,
  input  logic               cpu_strobe,
  input  logic [15:0]        cpu_addr,
  input  logic               cpu_we,
  input  logic [7:0]         cpu_din,
  input  logic [SRAM_AW-1:0] card_addr,
  input  logic               card_ram_rd,
  input  logic               card_ram_we,
  input  logic [7:0]         rom_data,
  input  logic               vid_req,
  input  logic [15:0]        vid_addr,
  output logic [7:0]         cpu_dout,
  output logic               cpu_ack,
  output logic [7:0]         vid_dout,
  output logic               vid_ack,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [7:0]         sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [7:0]         sram_dq_i,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam logic [2:0] c_wait_load = 3'(SRAM_WAIT - 1);

  // Pending slots
  logic               r_cpu_pend;
  logic [15:0]        r_cpu_addr;
  logic               r_cpu_we;
  logic [7:0]         r_cpu_din;
  logic [SRAM_AW-1:0] r_card_addr;
  logic               r_card_rd;
  logic               r_card_we;
  logic [7:0]         r_rom_data;
  logic               r_vid_pend;
  logic [15:0]        r_vid_addr;

  // Sequencer
  state_t             r_state;
  state_t             w_state_next;
  logic               r_serve_vid;
  logic [2:0]         r_wait_cnt;
  logic [7:0]         r_rd_data;

  svc_t               w_svc;
  logic [SRAM_AW-1:0] w_cpu_sram_addr;
  logic [SRAM_AW-1:0] w_vid_sram_addr;
  logic               w_wait_done;
  logic               w_take_vid;
  logic               w_take_cpu;
  logic               w_vid_done;
  logic               w_cpu_sram_done;
  logic               w_cpu_fast_ack;

  lc_region_decode u_decode (
    .i_addr      (r_cpu_addr),
    .i_we        (r_cpu_we),
    .i_card_rd   (r_card_rd),
    .i_card_we   (r_card_we),
    .i_card_addr (r_card_addr),
    .o_svc       (w_svc),
    .o_sram_addr (w_cpu_sram_addr)
  );

  assign w_vid_sram_addr = VID_BASE + {2'b00, r_vid_addr};
  assign w_wait_done     = (r_wait_cnt == 3'd0);
  assign w_take_vid      = (r_state == ST_IDLE) && r_vid_pend;
  assign w_take_cpu      = (r_state == ST_IDLE) && !r_vid_pend && r_cpu_pend
                           && (w_svc == SVC_SRAM);
  assign w_vid_done      = (r_state == ST_RD_LATCH) && r_serve_vid;
  assign w_cpu_sram_done = ((r_state == ST_RD_LATCH) && !r_serve_vid)
                           || (r_state == ST_WR_HOLD);
  // Non-SRAM CPU completions yield to a video ack on the same edge; the slot
  // stays pending so the ack simply slips by one cycle.
  assign w_cpu_fast_ack  = r_cpu_pend && (w_svc != SVC_SRAM) && !w_vid_done;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take_vid) begin
          w_state_next = ST_RD_SETUP;
        end else if (w_take_cpu) begin
          w_state_next = r_cpu_we ? ST_WR_SETUP : ST_RD_SETUP;
        end
      end
      ST_RD_SETUP: w_state_next = ST_RD_WAIT;
      ST_RD_WAIT:  if (w_wait_done) w_state_next = ST_RD_LATCH;
      ST_RD_LATCH: w_state_next = ST_IDLE;
      ST_WR_SETUP: w_state_next = ST_WR_PULSE;
      ST_WR_PULSE: if (w_wait_done) w_state_next = ST_WR_HOLD;
      ST_WR_HOLD:  w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture. Completion clears a slot first so a capture on the
  // ack edge is kept.
  // --------------------------------------------------------------------------
  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      r_cpu_pend  <= 1'b0;
      r_cpu_addr  <= '0;
      r_cpu_we    <= 1'b0;
      r_cpu_din   <= '0;
      r_card_addr <= '0;
      r_card_rd   <= 1'b0;
      r_card_we   <= 1'b0;
      r_rom_data  <= '0;
      r_vid_pend  <= 1'b0;
      r_vid_addr  <= '0;
    end else begin
      if (w_cpu_fast_ack || w_cpu_sram_done) begin
        r_cpu_pend <= 1'b0;
      end
      if (cpu_strobe) begin
        r_cpu_pend  <= 1'b1;
        r_cpu_addr  <= cpu_addr;
        r_cpu_we    <= cpu_we;
        r_cpu_din   <= cpu_din;
        r_card_addr <= card_addr;
        r_card_rd   <= card_ram_rd;
        r_card_we   <= card_ram_we;
        r_rom_data  <= rom_data;
      end
      if (w_vid_done) begin
        r_vid_pend <= 1'b0;
      end
      if (vid_req) begin
        r_vid_pend <= 1'b1;
        r_vid_addr <= vid_addr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // SRAM pins and completion outputs. Strobes are registered, so the action
  // of each state appears on the pins from the following cycle: OE_n/WE_n
  // are low exactly for the SRAM_WAIT cycles spent in RD_WAIT / WR_PULSE.
  // Read data is captured on the edge that ends RD_WAIT, while OE_n is still
  // low, and presented with the ack on leaving RD_LATCH.
  // --------------------------------------------------------------------------
  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      sram_addr   <= '0;
      sram_dq_o   <= '0;
      sram_dq_oe  <= 1'b0;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_dout    <= '0;
      vid_dout    <= '0;
      r_serve_vid <= 1'b0;
      r_wait_cnt  <= '0;
      r_rd_data   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_take_vid) begin
            r_serve_vid <= 1'b1;
            sram_addr   <= w_vid_sram_addr;
          end else if (w_take_cpu) begin
            r_serve_vid <= 1'b0;
            sram_addr   <= w_cpu_sram_addr;
            if (r_cpu_we) begin
              sram_dq_o  <= r_cpu_din;
              sram_dq_oe <= 1'b1;
            end
          end
        end
        ST_RD_SETUP: begin
          sram_oe_n  <= 1'b0;
          r_wait_cnt <= c_wait_load;
        end
        ST_RD_WAIT: begin
          if (w_wait_done) begin
            sram_oe_n <= 1'b1;
            r_rd_data <= sram_dq_i;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        ST_RD_LATCH: begin
          if (r_serve_vid) begin
            vid_dout <= r_rd_data;
            vid_ack  <= 1'b1;
          end else begin
            cpu_dout <= r_rd_data;
            cpu_ack  <= 1'b1;
          end
        end
        ST_WR_SETUP: begin
          sram_we_n  <= 1'b0;
          r_wait_cnt <= c_wait_load;
        end
        ST_WR_PULSE: begin
          if (w_wait_done) begin
            sram_we_n <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        ST_WR_HOLD: begin
          cpu_ack    <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        default: begin
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase

      if (w_cpu_fast_ack) begin
        cpu_ack <= 1'b1;
        if (w_svc == SVC_IO) begin
          cpu_dout <= OPEN_BUS;
        end else if (w_svc == SVC_ROM) begin
          cpu_dout <= r_rom_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lc_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc_sram_ctrl
// Description : Directed self-checking bench for lc_sram_ctrl with a
//               behavioural 256Kx8 SRAM attached to the pins.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc_sram_ctrl;

  logic        mclk28 = 1'b0;
  logic        reset_in;
  logic        cpu_strobe;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic [17:0] card_addr;
  logic        card_ram_rd;
  logic        card_ram_we;
  logic [7:0]  rom_data;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [7:0]  vid_dout;
  logic        vid_ack;
  logic [17:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_i;
  logic        sram_oe_n;
  logic        sram_we_n;

  int n_cmp = 0;
  int n_bad = 0;

  int oe_low = 0;
  int we_low = 0;
  int ack_both = 0;
  int strobe_clash = 0;

  logic [7:0] mem [0:262143];

  always #5 mclk28 = ~mclk28;

  lc_sram_ctrl #(.SRAM_WAIT(1), .VID_BASE(18'h00000)) dut (
    .mclk28      (mclk28),
    .reset_in    (reset_in),
    .cpu_strobe  (cpu_strobe),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_din     (cpu_din),
    .card_addr   (card_addr),
    .card_ram_rd (card_ram_rd),
    .card_ram_we (card_ram_we),
    .rom_data    (rom_data),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .vid_dout    (vid_dout),
    .vid_ack     (vid_ack),
    .sram_addr   (sram_addr),
    .sram_dq_o   (sram_dq_o),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_i   (sram_dq_i),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n)
  );

  // Behavioural SRAM: asynchronous read under OE_n, write on WE_n release.
  assign sram_dq_i = sram_oe_n ? 8'h00 : mem[sram_addr];
  always @(posedge sram_we_n) begin
    if (sram_dq_oe) mem[sram_addr] <= sram_dq_o;
  end

  always @(negedge mclk28) begin
    if (!sram_oe_n) oe_low++;
    if (!sram_we_n) we_low++;
    if (cpu_ack && vid_ack) ack_both++;
    if (!sram_oe_n && !sram_we_n) strobe_clash++;
  end

  task automatic tick();
    @(posedge mclk28);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one CPU request for a single cycle; returns after the capture edge.
  task automatic cpu_req(input logic [15:0] a, input logic w, input logic [7:0] d,
                         input logic [17:0] ca, input logic rd, input logic wen,
                         input logic [7:0] rom);
    cpu_strobe = 1'b1; cpu_addr = a; cpu_we = w; cpu_din = d;
    card_addr = ca; card_ram_rd = rd; card_ram_we = wen; rom_data = rom;
    oe_low = 0; we_low = 0;
    tick();
    cpu_strobe = 1'b0;
  endtask

  // Cycles from capture edge to cpu_ack; 99 if it never arrives.
  task automatic wait_cpu_ack(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack && lat < 20);
    if (!cpu_ack) lat = 99;
  endtask

  initial begin
    int lat;
    int vl, cl;
    logic [7:0] vdat, cdat;
    int acks;

    reset_in = 1'b1; cpu_strobe = 1'b0; cpu_addr = '0; cpu_we = 1'b0;
    cpu_din = '0; card_addr = '0; card_ram_rd = 1'b0; card_ram_we = 1'b0;
    rom_data = '0; vid_req = 1'b0; vid_addr = '0;
    mem[18'h00400] = 8'h5A;
    mem[18'h02000] = 8'hC3;
    mem[18'h0C123] = 8'h00;
    mem[18'h01000] = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_dq_oe", sram_dq_oe, 1'b0);
    check("rst_addr", sram_addr, 18'h0);
    check("rst_acks", {cpu_ack, vid_ack}, 2'b00);
    check("rst_douts", {cpu_dout, vid_dout}, 16'h0000);
    reset_in = 1'b0;
    tick();

    // SRAM read $0400
    cpu_req(16'h0400, 1'b0, 8'h00, 18'h0, 1'b0, 1'b0, 8'h00);
    wait_cpu_ack(lat);
    check("rd0400_lat", lat, 4);
    check("rd0400_data", cpu_dout, 8'h5A);
    check("rd0400_oe_cycles", oe_low, 1);
    tick();

    // ROM read $E000
    cpu_req(16'hE000, 1'b0, 8'h00, 18'h0E000, 1'b0, 1'b0, 8'hA9);
    wait_cpu_ack(lat);
    check("romE000_lat", lat, 1);
    check("romE000_data", cpu_dout, 8'hA9);
    check("romE000_oe_cycles", oe_low, 0);
    tick();

    // Card RAM write $D123 -> 0C123
    cpu_req(16'hD123, 1'b1, 8'h3C, 18'h0C123, 1'b1, 1'b1, 8'h00);
    wait_cpu_ack(lat);
    check("wrD123_lat", lat, 4);
    check("wrD123_addr", sram_addr, 18'h0C123);
    check("wrD123_we_cycles", we_low, 1);
    check("wrD123_mem", mem[18'h0C123], 8'h3C);
    tick();
    check("wrD123_dq_oe_off", sram_dq_oe, 1'b0);

    // Same write, write-protected
    cpu_req(16'hD123, 1'b1, 8'h77, 18'h0C123, 1'b1, 1'b0, 8'h00);
    wait_cpu_ack(lat);
    check("wpD123_lat", lat, 1);
    check("wpD123_we_cycles", we_low, 0);
    check("wpD123_mem", mem[18'h0C123], 8'h3C);
    tick();

    // Simultaneous CPU read $2000 and video fetch $0400
    vid_req = 1'b1; vid_addr = 16'h0400;
    cpu_req(16'h2000, 1'b0, 8'h00, 18'h0, 1'b0, 1'b0, 8'h00);
    vid_req = 1'b0;
    vl = 99; cl = 99; vdat = 8'h00; cdat = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (vid_ack && vl == 99) begin vl = c; vdat = vid_dout; end
      if (cpu_ack && cl == 99) begin cl = c; cdat = cpu_dout; end
    end
    check("both_vid_lat", vl, 4);
    check("both_vid_data", vdat, 8'h5A);
    check("both_cpu_lat", cl, 8);
    check("both_cpu_data", cdat, 8'hC3);

    // Reset during WR_PULSE aborts the write
    cpu_req(16'h1000, 1'b1, 8'h11, 18'h0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    check("abort_we_low", sram_we_n, 1'b0);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("abort_we_n", sram_we_n, 1'b1);
    check("abort_dq_oe", sram_dq_oe, 1'b0);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      if (cpu_ack || vid_ack) acks++;
      if (!sram_oe_n || !sram_we_n) acks++;
      tick();
    end
    check("abort_idle_quiet", acks, 0);
    check("abort_mem", mem[18'h01000], 8'h00);

    cpu_req(16'h0400, 1'b0, 8'h00, 18'h0, 1'b0, 1'b0, 8'h00);
    wait_cpu_ack(lat);
    check("post_abort_lat", lat, 4);
    check("post_abort_data", cpu_dout, 8'h5A);
    tick();

    // I/O read $C030
    cpu_req(16'hC030, 1'b0, 8'h00, 18'h0, 1'b1, 1'b1, 8'h12);
    wait_cpu_ack(lat);
    check("ioC030_lat", lat, 1);
    check("ioC030_data", cpu_dout, 8'hFF);
    check("ioC030_oe_cycles", oe_low, 0);
    tick();

    check("acks_never_coincide", ack_both, 0);
    check("oe_we_never_both_low", strobe_clash, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
